// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin front end that lets two requesters share one
// combinational ALU (add, sub, and, or, not, slt). Each request is captured,
// evaluated for one cycle, and returned on a single tagged response channel.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready to grant one requester and capture its operation
// EXEC    | ALU evaluates captured operands, result loads into rsp regs
// HOLD    | response presented until the consumer takes it
module alu_share_sched #(
  parameter int unsigned size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [2:0]      req0_op,
  input  logic [size-1:0] req0_a,
  input  logic [size-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [2:0]      req1_op,
  input  logic [size-1:0] req1_a,
  input  logic [size-1:0] req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [size-1:0] rsp_data,
  output logic            rsp_cout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam logic [size:0] ONE = {{size{1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic            last_grant_q;
  logic [2:0]      op_q;
  logic [size-1:0] a_q, b_q;
  logic            id_q;

  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [size-1:0] rsp_data_q;
  logic            rsp_cout_q;

  logic            grant0, grant1;
  logic            accept0, accept1;

  logic [size:0]   sum_add, sum_sub, sum_slt;
  logic [size-1:0] alu_data;
  logic            alu_cout;

  // Round-robin grant: a lone requester always wins; on a tie the one that
  // was not served last wins, so continuous traffic alternates.
  always_comb begin
    grant0  = req0_valid & (~req1_valid | last_grant_q);
    grant1  = req1_valid & (~req0_valid | ~last_grant_q);
    accept0 = req0_valid & req0_ready;
    accept1 = req1_valid & req1_ready;
  end

  assign req0_ready = (state_q == ST_IDLE) & grant0;
  assign req1_ready = (state_q == ST_IDLE) & grant1;

  // Next-state logic for the IDLE -> EXEC -> HOLD loop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept0 || accept1) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_HOLD;
      ST_HOLD: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the granted requester's operation; last_grant resets to 1 so
  // requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept0 || accept1) begin
      op_q         <= accept1 ? req1_op : req0_op;
      a_q          <= accept1 ? req1_a  : req0_a;
      b_q          <= accept1 ? req1_b  : req0_b;
      id_q         <= accept1;
      last_grant_q <= accept1;
    end
  end

  // Shared ALU. Subtractions use a + ~b + 1 so the carry out means "no
  // borrow"; slt reports the inverted sign of b - a, so a == b yields 1.
  always_comb begin
    sum_add  = {1'b0, a_q} + {1'b0, b_q};
    sum_sub  = {1'b0, a_q} + {1'b0, ~b_q} + ONE;
    sum_slt  = {1'b0, b_q} + {1'b0, ~a_q} + ONE;
    alu_data = '0;
    alu_cout = 1'b0;
    case (op_q)
      OP_ADD: {alu_cout, alu_data} = sum_add;
      OP_SUB: {alu_cout, alu_data} = sum_sub;
      OP_AND: alu_data = a_q & b_q;
      OP_OR:  alu_data = a_q | b_q;
      OP_NOT: alu_data = ~a_q;
      OP_SLT: begin
        alu_data = (~sum_slt[size-1:0]) >> (size - 1);
        alu_cout = sum_slt[size];
      end
      default: begin
        alu_data = '0;
        alu_cout = 1'b0;
      end
    endcase
  end

  // Response registers: load in EXEC, hold through HOLD, keep data after
  // the handshake and only drop the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_cout_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= id_q;
      rsp_data_q  <= alu_data;
      rsp_cout_q  <= alu_cout;
    end else if (state_q == ST_HOLD && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_alu_share_sched.sv
// Scoreboard bench for alu_share_sched: drivers issue requests, a monitor
// predicts grants and results from a behavioural model and checks responses.
module tb_alu_share_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1, rdy0, rdy1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       rsp_valid, rsp_rdy, rsp_id, rsp_cout;
  logic [7:0] rsp_data;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  logic [9:0] sb[$];      // {id, cout, data}
  logic       acc_log[$]; // ids of accepted requests, in order
  logic       busy = 1'b0;
  logic       last = 1'b1;
  int         lat  = 0;
  logic       hold_prev = 1'b0;
  logic [9:0] hold_val;
  logic       d0, d1;

  always #5 clk = ~clk;

  alu_share_sched #(.size(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0), .req0_ready(rdy0), .req0_op(op0), .req0_a(a0), .req0_b(b0),
    .req1_valid(v1), .req1_ready(rdy1), .req1_op(op1), .req1_a(a1), .req1_b(b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural ALU: {cout, data} from plain integer arithmetic.
  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai, bi, dd;
    logic [8:0] r;
    ai = int'(a);
    bi = int'(b);
    r  = 9'd0;
    case (op)
      3'd0: begin r[7:0] = 8'(ai + bi); r[8] = (ai + bi) > 255; end
      3'd1: begin r[7:0] = 8'(ai - bi); r[8] = ai >= bi; end
      3'd2: r[7:0] = a & b;
      3'd3: r[7:0] = a | b;
      3'd4: r[7:0] = ~a;
      3'd5: begin
        dd = (bi - ai + 256) % 256;
        r[7:0] = (dd < 128) ? 8'd1 : 8'd0;
        r[8]   = bi >= ai;
      end
      default: r = 9'd0;
    endcase
    return r;
  endfunction

  // Monitor: predicts grants, latency and stability, and scores responses.
  initial begin
    logic e0, e1;
    logic [9:0] got, exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        busy = 1'b0; last = 1'b1; lat = 0; hold_prev = 1'b0;
      end else begin
        if (lat == 2) begin
          chk("lat_not_early", 32'(rsp_valid), 32'd0);
          lat = 1;
        end else if (lat == 1) begin
          chk("lat_valid", 32'(rsp_valid), 32'd1);
          lat = 0;
        end
        if (hold_prev)
          chk("hold_stable", 32'({rsp_id, rsp_cout, rsp_data}), 32'(hold_val));
        e0 = !busy && v0 && (!v1 || last);
        e1 = !busy && v1 && (!v0 || !last);
        chk("ready0", 32'(rdy0), 32'(e0));
        chk("ready1", 32'(rdy1), 32'(e1));
        if (rdy0 && rdy1) chk("ready_exclusive", 32'({rdy0, rdy1}), 32'd0);
        if (v0 && rdy0) begin
          sb.push_back({1'b0, model(op0, a0, b0)});
          acc_log.push_back(1'b0);
          busy = 1'b1; last = 1'b0; lat = 2;
        end else if (v1 && rdy1) begin
          sb.push_back({1'b1, model(op1, a1, b1)});
          acc_log.push_back(1'b1);
          busy = 1'b1; last = 1'b1; lat = 2;
        end
        if (rsp_valid && rsp_rdy) begin
          got = {rsp_id, rsp_cout, rsp_data};
          if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(got), 32'h3ff);
          end else begin
            exp = sb.pop_front();
            chk("rsp_id",   32'(rsp_id),   32'(exp[9]));
            chk("rsp_cout", 32'(rsp_cout), 32'(exp[8]));
            chk("rsp_data", 32'(rsp_data), 32'(exp[7:0]));
          end
          busy = 1'b0;
        end
        hold_prev = rsp_valid && !rsp_rdy;
        hold_val  = {rsp_id, rsp_cout, rsp_data};
      end
    end
  end

  // Issue one request and hold it until accepted; called at posedge+1.
  task automatic issue(input int r, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, output int waited);
    logic hs;
    waited = 0;
    if (r == 0) begin op0 = op; a0 = a; b0 = b; v0 = 1'b1; end
    else        begin op1 = op; a1 = a; b1 = b; v1 = 1'b1; end
    forever begin
      @(negedge clk);
      hs = (r == 0) ? (v0 && rdy0) : (v1 && rdy1);
      if (hs) break;
      waited++;
      if (waited > 200) begin
        chk("issue_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    if (r == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic drv(input int r, input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      issue(r, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), w);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    rsp_rdy = 1'b1;
    while ((sb.size() != 0 || busy) && g < 100) begin @(posedge clk); #1; g++; end
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w, g;
    logic h0, h1;
    rst_n = 1'b0; v0 = 0; v1 = 0; rsp_rdy = 0;
    op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; d0 = 0; d1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id",    32'(rsp_id),    32'd0);
    chk("rst_data",  32'(rsp_data),  32'd0);
    chk("rst_cout",  32'(rsp_cout),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_rdy = 1'b1;

    // Directed operations from the test plan.
    issue(0, 3'd0, 8'h0F, 8'h01, w);
    chk("first_ready_wait", 32'(w), 32'd0);
    issue(1, 3'd1, 8'h03, 8'h05, w);
    issue(1, 3'd1, 8'h05, 8'h03, w);
    issue(0, 3'd5, 8'd3, 8'd5, w);
    issue(0, 3'd5, 8'd5, 8'd3, w);
    issue(0, 3'd5, 8'd7, 8'd7, w);
    issue(1, 3'd6, 8'hA5, 8'h5A, w);
    issue(1, 3'd7, 8'hFF, 8'hFF, w);
    issue(0, 3'd4, 8'h3C, 8'h00, w);
    issue(1, 3'd2, 8'hF0, 8'h3C, w);
    drain();

    // Continuous requests from both sides must alternate, starting at 0.
    issue(1, 3'd3, 8'h11, 8'h22, w);
    drain();
    acc_log.delete();
    op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom);
    op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom);
    v0 = 1'b1; v1 = 1'b1;
    g = 0;
    while (acc_log.size() < 6 && g < 200) begin
      @(negedge clk);
      h0 = v0 && rdy0;
      h1 = v1 && rdy1;
      @(posedge clk); #1;
      if (h0) begin op0 = 3'($urandom_range(0, 7)); a0 = 8'($urandom); b0 = 8'($urandom); end
      if (h1) begin op1 = 3'($urandom_range(0, 7)); a1 = 8'($urandom); b1 = 8'($urandom); end
      g++;
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("alt_count", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++)
      chk($sformatf("alt_id%0d", i), 32'(acc_log[i]), 32'(i % 2));
    drain();

    // Back-pressure: response held 5 cycles, pending req1 waits.
    rsp_rdy = 1'b0;
    issue(0, 3'd3, 8'h81, 8'h18, w);
    op1 = 3'd0; a1 = 8'h80; b1 = 8'h80; v1 = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!rsp_valid && g < 20);
    chk("hold_rise", 32'(rsp_valid), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_ready", 32'({rdy0, rdy1}), 32'd0);
    end
    @(posedge clk); #1 rsp_rdy = 1'b1;
    @(posedge clk); #1 rsp_rdy = 1'b0;
    @(negedge clk);
    chk("hold_drop", 32'(rsp_valid), 32'd0);
    chk("next_accept", 32'(rdy1), 32'd1);
    @(posedge clk); #1 v1 = 1'b0;
    drain();

    // Randomized traffic from both requesters with random back-pressure.
    d0 = 0; d1 = 0;
    fork
      begin drv(0, 25); d0 = 1; end
      begin drv(1, 25); d1 = 1; end
      begin
        while (!(d0 && d1)) begin
          @(posedge clk); #1;
          rsp_rdy = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    // Reset during EXEC with FF+01 in flight: no response may appear.
    rsp_rdy = 1'b0;
    issue(0, 3'd0, 8'hFF, 8'h01, w);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_data",  32'(rsp_data),  32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_rdy = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // First tie after reset goes to requester 0.
    acc_log.delete();
    @(posedge clk); #1;
    op0 = 3'd0; a0 = 8'h01; b0 = 8'h02; op1 = 3'd0; a1 = 8'h03; b1 = 8'h04;
    v0 = 1'b1; v1 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 v0 = 1'b0; v1 = 1'b0;
    chk("rst_tie_count", 32'(acc_log.size()), 32'd1);
    if (acc_log.size() > 0) chk("rst_tie_id", 32'(acc_log[0]), 32'd0);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vec_cnt, miss_cnt);
    $fatal(1, "watchdog");
  end

endmodule
